// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and the halt opcode,
// used by the instruction fetch unit and the decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [7:0] HLT_CODE = 8'b00001010;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the program-memory read address (the PC),
// waits out the registered-read latency, captures the instruction byte and
// offers it to the decoder over valid/ready. Stops after delivering HLT.
// Optional feature macro: FETCH_CNT_EN adds fetch_cnt, a saturating count of
// completed transfers cleared by reset and by start.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter int                MEM_LAT  = 1,
  parameter logic [DATA_W-1:0] HLT_CODE = cpu_pkg::HLT_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
`ifdef FETCH_CNT_EN
  output logic [7:0]        fetch_cnt,
`endif
  output logic              halted
);

  // Wait counter must hold MEM_LAT; keep at least one bit when MEM_LAT is 0.
  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LAT);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  wait_cnt;
  logic              idle_like;
  logic              xfer;
  logic              is_hlt;

  assign mem_addr  = pc;
  assign idle_like = (state == IDLE) || (state == HALT);
  assign xfer      = (state == VALID) && instr_ready;
  assign is_hlt    = (instr == HLT_CODE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a jump during FETCH restarts the wait instead of capturing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (!jump_en && (wait_cnt == '0)) state_nxt = VALID;
      VALID: begin
        if (instr_ready)  state_nxt = is_hlt ? HALT : FETCH;
        else if (jump_en) state_nxt = FETCH;
      end
      HALT:  if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: busy = 1'b1;
      VALID: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
      end
      HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // PC, wait counter and captured instruction. A transfer that coincides with
  // a jump still completes; the jump only chooses the following address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      wait_cnt <= '0;
      instr    <= '0;
      pc_out   <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc       <= '0;
            wait_cnt <= WAIT_LOAD;
          end
        end
        FETCH: begin
          if (jump_en) begin
            pc       <= jump_addr;
            wait_cnt <= WAIT_LOAD;
          end else if (wait_cnt == '0) begin
            instr  <= mem_dout;
            pc_out <= pc;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            if (!is_hlt) begin
              pc       <= jump_en ? jump_addr : pc + 1'b1;
              wait_cnt <= WAIT_LOAD;
            end
          end else if (jump_en) begin
            pc       <= jump_addr;
            wait_cnt <= WAIT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  // Saturating count of completed transfers; a restart begins a fresh count.
  always_ff @(posedge clk) begin
    if (reset)                       fetch_cnt <= '0;
    else if (start && idle_like)     fetch_cnt <= '0;
    else if (xfer && fetch_cnt != 8'hFF) fetch_cnt <= fetch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: registered-read program memory model,
// directed scenarios followed by randomized ready/jump/start/reset traffic,
// with a transfer-level scoreboard checked by an independent monitor.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 1;
  localparam int DEPTH   = 16;
  localparam logic [7:0] HLT = 8'h0A;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] pc_out;
  logic              busy;
  logic              halted;
`ifdef FETCH_CNT_EN
  logic [7:0]        fetch_cnt;
`endif

  instr_fetch_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .pc_out     (pc_out),
    .busy       (busy),
`ifdef FETCH_CNT_EN
    .fetch_cnt  (fetch_cnt),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program memory: 0x01..0x0D at 0..12 (HLT at 9), non-HLT filler above.
  logic [7:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (i < 13) ? 8'(i + 1) : 8'(8'h20 + i);
  end

  always @(posedge clk) mem_dout <= mem[mem_addr];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: whether a program is running, the address of the
  // next instruction expected on the decoder side, and the transfer count.
  bit         running   = 1'b0;
  int         exp_q[$];
  int         m_cnt     = 0;
  int         prev_xfer = -1;
  int         idle_cyc  = 0;
  bit         chk_period = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: evaluates what the coming clock edge does and checks transfers.
  always @(negedge clk) begin
`ifdef FETCH_CNT_EN
    chk("fetch_cnt", {24'd0, fetch_cnt}, m_cnt);
`endif
    if (reset) begin
      running = 1'b0;
      exp_q.delete();
      m_cnt   = 0;
    end else if (!running) begin
      chk("no valid while stopped", {31'd0, instr_valid}, 0);
      if (start) begin
        running   = 1'b1;
        exp_q.delete();
        exp_q.push_back(0);
        m_cnt     = 0;
        prev_xfer = -1;
        idle_cyc  = 0;
      end
    end else if (instr_valid && instr_ready) begin
      int a;
      idle_cyc = 0;
      if (exp_q.size() == 0) begin
        chk("unexpected transfer", 1, 0);
      end else begin
        a = exp_q.pop_front();
        chk("xfer instr", {24'd0, instr}, {24'd0, mem[a]});
        chk("xfer pc_out", {28'd0, pc_out}, a);
        if (chk_period && prev_xfer >= 0)
          chk("transfer period", cyc - prev_xfer, MEM_LAT + 2);
        prev_xfer = cyc;
        if (m_cnt < 255) m_cnt++;
        if (mem[a] == HLT) begin
          running = 1'b0;
          exp_q.delete();
        end else begin
          exp_q.push_back(jump_en ? int'(jump_addr) : (a + 1) % DEPTH);
        end
      end
    end else begin
      if (jump_en) begin
        exp_q.delete();
        exp_q.push_back(int'(jump_addr));
      end
      idle_cyc++;
      if (idle_cyc > 100) begin
        chk("transfer timeout", idle_cyc, 0);
        idle_cyc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else tick();
    end
    chk("wait_valid timeout", {31'd0, found}, 1);
  endtask

  task automatic accept_one();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_valid();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " mem_addr"}, {28'd0, mem_addr}, 0);
    chk({tag, " instr"}, {24'd0, instr}, 0);
    chk({tag, " pc_out"}, {28'd0, pc_out}, 0);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, 0);
    chk({tag, " busy"}, {31'd0, busy}, 0);
    chk({tag, " halted"}, {31'd0, halted}, 0);
  endtask

  initial begin
    bit done;
    reset = 1'b1; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Scenario 1: run to HLT with ready held high.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("latency e0 valid", {31'd0, instr_valid}, 0);
    chk("latency e0 busy", {31'd0, busy}, 1);
    tick();
    chk("latency e0+1 valid", {31'd0, instr_valid}, 0);
    tick();
    chk("latency e0+2 valid", {31'd0, instr_valid}, 1);
    chk("first instr", {24'd0, instr}, 8'h01);
    chk("first pc_out", {28'd0, pc_out}, 0);
    chk_period  = 1'b1;
    instr_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (!running) done = 1'b1;
    end
    chk("halt reached", {31'd0, done}, 1);
    instr_ready = 1'b0;
    chk_period  = 1'b0;
    repeat (3) tick();
    chk("halted", {31'd0, halted}, 1);
    chk("halt mem_addr", {28'd0, mem_addr}, 9);
    chk("halt busy", {31'd0, busy}, 0);
`ifdef FETCH_CNT_EN
    chk("fetch_cnt after run", {24'd0, fetch_cnt}, 10);
`endif

    // Scenario 2: restart from HALT, stall while holding 0x02.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart halted", {31'd0, halted}, 0);
`ifdef FETCH_CNT_EN
    chk("fetch_cnt cleared", {24'd0, fetch_cnt}, 0);
`endif
    wait_valid();
    chk("restart instr", {24'd0, instr}, 8'h01);
    accept_one();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall valid", {31'd0, instr_valid}, 1);
      chk("stall instr", {24'd0, instr}, 8'h02);
      chk("stall pc_out", {28'd0, pc_out}, 1);
    end
    accept_one();
    chk("after stall instr", {24'd0, instr}, 8'h03);

    // Scenario 3: jump to 12 during fetch of address 3, then wrap.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    jump_en = 1'b1; jump_addr = 4'd12;
    tick();
    jump_en = 1'b0;
    wait_valid();
    chk("jump instr", {24'd0, instr}, 8'h0D);
    chk("jump pc_out", {28'd0, pc_out}, 12);
    for (int k = 1; k <= 4; k++) begin
      accept_one();
      chk("wrap pc_out", {28'd0, pc_out}, (12 + k) % DEPTH);
    end

    // Scenario 4: jump coinciding with acceptance at address 4.
    repeat (4) accept_one();
    chk("pre-jump pc_out", {28'd0, pc_out}, 4);
    chk("pre-jump instr", {24'd0, instr}, 8'h05);
    instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 4'd11;
    tick();
    instr_ready = 1'b0; jump_en = 1'b0;
    wait_valid();
    chk("jump+xfer pc_out", {28'd0, pc_out}, 11);
    chk("jump+xfer instr", {24'd0, instr}, 8'h0C);

    // Scenario 5: reset in the middle of a fetch.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero_outputs("mid-fetch reset");
    tick();
    chk("post-reset busy", {31'd0, busy}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();
    chk("resume instr", {24'd0, instr}, 8'h01);
    chk("resume pc_out", {28'd0, pc_out}, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      jump_en     = 1'b0;
      start       = 1'b0;
      reset       = ($urandom_range(0, 699) == 0);
      if (running) begin
        if ($urandom_range(0, 19) == 0) begin
          jump_en   = 1'b1;
          jump_addr = 4'($urandom_range(0, DEPTH - 1));
        end
        start = ($urandom_range(0, 39) == 0);
      end else begin
        start = ($urandom_range(0, 2) == 0);
      end
      tick();
    end
    instr_ready = 1'b0; jump_en = 1'b0; start = 1'b0; reset = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
